// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared state type and default widths for the perceptron layer
package perceptron_pkg;
  localparam int IN_W_DEF       = 8;
  localparam int PCPTRN_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/perceptron_wbank.sv
// rtl/perceptron_wbank.sv - per-neuron weight register file, sync write, comb read
module perceptron_wbank #(
  parameter int NUM_NEURONS = 4,
  parameter int IN_W        = perceptron_pkg::IN_W_DEF,
  localparam int AW         = $clog2(NUM_NEURONS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [IN_W-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [IN_W-1:0] o_rdata
);
  logic [IN_W-1:0] r_mem [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/perceptron_layer_seq.sv
// rtl/perceptron_layer_seq.sv - time-multiplexes one perceptron across NUM_NEURONS weight sets
module perceptron_layer_seq
  import perceptron_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int IN_W        = perceptron_pkg::IN_W_DEF,
  parameter int PCPTRN_LAT  = perceptron_pkg::PCPTRN_LAT_DEF,
  localparam int AW         = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [IN_W-1:0]        cfg_wdata,
  output logic                   cfg_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  output logic                   busy,
  output logic [IN_W-1:0]        pcp_in,
  output logic [IN_W-1:0]        pcp_weights,
  input  logic                   pcp_result
);
  localparam int CW = (PCPTRN_LAT > 1) ? $clog2(PCPTRN_LAT) : 1;

  state_t                 r_state, w_next;
  logic [IN_W-1:0]        r_vec;
  logic [AW-1:0]          r_idx;
  logic [CW-1:0]          r_wcnt;
  logic [NUM_NEURONS-1:0] r_out;
  logic                   r_cfg_err;
  logic [IN_W-1:0]        w_rdata;
  logic                   w_addr_ok, w_wr_ok, w_last_wait, w_last_idx, w_drive;

  assign w_addr_ok   = (int'(cfg_addr) < NUM_NEURONS);
  assign w_wr_ok     = cfg_we && w_addr_ok && (r_state == IDLE);
  assign w_last_wait = (r_wcnt == CW'(PCPTRN_LAT - 1));
  assign w_last_idx  = (r_idx == AW'(NUM_NEURONS - 1));
  assign w_drive     = (r_state == ISSUE) || (r_state == WAIT);

  perceptron_wbank #(.NUM_NEURONS(NUM_NEURONS), .IN_W(IN_W)) u_wbank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_ok),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_last_wait) w_next = w_last_idx ? DONE : ISSUE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_vec     <= '0;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_out     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= cfg_we && !w_wr_ok;
      case (r_state)
        IDLE: if (in_valid) begin
          r_vec <= in_data;
          r_idx <= '0;
        end
        ISSUE: r_wcnt <= '0;
        WAIT: begin
          // result is valid only at the end of the last wait cycle
          if (w_last_wait) begin
            r_out[r_idx] <= pcp_result;
            if (!w_last_idx) r_idx <= r_idx + AW'(1);
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_err     = r_cfg_err;
  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign out_data    = r_out;
  assign busy        = (r_state != IDLE);
  assign pcp_in      = w_drive ? r_vec : '0;
  assign pcp_weights = w_drive ? w_rdata : '0;
endmodule

// File: tb/tb_perceptron_layer_seq.sv
// tb/tb_perceptron_layer_seq.sv - self-checking bench for perceptron_layer_seq
module tb_perceptron_layer_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int NN [3] = '{4, 2, 3};
  int LL [3] = '{1, 3, 2};

  logic       cfg_we [3], in_valid [3], out_ready [3];
  logic [3:0] cfg_addr [3];
  logic [7:0] cfg_wdata [3], in_data [3];
  logic       cfg_err [3], in_ready [3], out_valid [3], busy [3], pcp_result [3];
  logic [7:0] pcp_in [3], pcp_w [3];
  logic [3:0] od0;
  logic [1:0] od1;
  logic [2:0] od2;
  logic [15:0] out_data [3];
  logic [3:0] pipe [3];

  logic [7:0] wm [3][4];
  int n_vec = 0;
  int n_err = 0;

  assign out_data[0] = {12'd0, od0};
  assign out_data[1] = {14'd0, od1};
  assign out_data[2] = {13'd0, od2};

  perceptron_layer_seq #(.NUM_NEURONS(4), .IN_W(8), .PCPTRN_LAT(1)) u_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr[0][1:0]),
    .cfg_wdata(cfg_wdata[0]), .cfg_err(cfg_err[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od0), .busy(busy[0]), .pcp_in(pcp_in[0]),
    .pcp_weights(pcp_w[0]), .pcp_result(pcp_result[0]));

  perceptron_layer_seq #(.NUM_NEURONS(2), .IN_W(8), .PCPTRN_LAT(3)) u_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr[1][0:0]),
    .cfg_wdata(cfg_wdata[1]), .cfg_err(cfg_err[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od1), .busy(busy[1]), .pcp_in(pcp_in[1]),
    .pcp_weights(pcp_w[1]), .pcp_result(pcp_result[1]));

  perceptron_layer_seq #(.NUM_NEURONS(3), .IN_W(8), .PCPTRN_LAT(2)) u_c (
    .clk(clk), .reset(reset), .cfg_we(cfg_we[2]), .cfg_addr(cfg_addr[2][1:0]),
    .cfg_wdata(cfg_wdata[2]), .cfg_err(cfg_err[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od2), .busy(busy[2]), .pcp_in(pcp_in[2]),
    .pcp_weights(pcp_w[2]), .pcp_result(pcp_result[2]));

  // external perceptrons: parity of in&weights delayed by each instance's latency
  always_ff @(posedge clk) begin
    for (int d = 0; d < 3; d++) pipe[d] <= {pipe[d][2:0], ^(pcp_in[d] & pcp_w[d])};
  end
  assign pcp_result[0] = pipe[0][0];
  assign pcp_result[1] = pipe[1][2];
  assign pcp_result[2] = pipe[2][1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_out(input int d, input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NN[d]; i++) r[i] = ^(v & wm[d][i]);
    return r;
  endfunction

  task automatic cfg_write(input int d, input int a, input logic [7:0] v, input logic exp_err);
    cfg_we[d] = 1'b1;
    cfg_addr[d] = 4'(a);
    cfg_wdata[d] = v;
    step();
    cfg_we[d] = 1'b0;
    check_eq("cfg_err", 32'(cfg_err[d]), 32'(exp_err));
    if (!exp_err) wm[d][a] = v;
  endtask

  task automatic run_vec(input int d, input logic [7:0] vec, input int hold, input logic [7:0] pend,
                         input int inj, input logic [3:0] ia, input logic [7:0] idat);
    int cnt;
    int per;
    logic [15:0] exp;
    per = LL[d] + 1;
    exp = model_out(d, vec);
    check_eq("in_ready_idle", 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_data[d] = vec;
    step();
    in_valid[d] = 1'b0;
    in_data[d] = 8'($urandom);
    cnt = 1;
    while (!out_valid[d] && cnt < 400) begin
      if (cnt <= NN[d] * per) begin
        check_eq("pcp_in", 32'(pcp_in[d]), 32'(vec));
        check_eq("pcp_weights", 32'(pcp_w[d]), 32'(wm[d][(cnt-1)/per]));
        check_eq("in_ready_busy", 32'(in_ready[d]), 32'd0);
      end
      if (inj > 0 && cnt == inj + 1) check_eq("cfg_err_pulse", 32'(cfg_err[d]), 32'd1);
      if (inj > 0 && cnt == inj + 2) check_eq("cfg_err_clear", 32'(cfg_err[d]), 32'd0);
      cfg_we[d] = (inj > 0 && cnt == inj);
      cfg_addr[d] = ia;
      cfg_wdata[d] = idat;
      if (hold == 0) out_ready[d] = 1'($urandom_range(0, 1));
      step();
      cnt++;
    end
    cfg_we[d] = 1'b0;
    check_eq("latency", 32'(cnt), 32'(NN[d] * per + 1));
    check_eq("out_data", 32'(out_data[d]), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      out_ready[d] = 1'b0;
      in_valid[d] = 1'b1;
      in_data[d] = pend;
      check_eq("stall_valid", 32'(out_valid[d]), 32'd1);
      check_eq("stall_data", 32'(out_data[d]), 32'(exp));
      check_eq("stall_in_ready", 32'(in_ready[d]), 32'd0);
      check_eq("stall_pcp_w", 32'(pcp_w[d]), 32'd0);
      step();
    end
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    check_eq("post_valid", 32'(out_valid[d]), 32'd0);
    check_eq("post_in_ready", 32'(in_ready[d]), 32'd1);
    check_eq("post_busy", 32'(busy[d]), 32'd0);
    check_eq("post_pcp_in", 32'(pcp_in[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      cfg_we[d] = 0; in_valid[d] = 0; out_ready[d] = 0;
      cfg_addr[d] = 0; cfg_wdata[d] = 0; in_data[d] = 0;
      for (int i = 0; i < 4; i++) wm[d][i] = 8'h00;
    end
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready[d]), 32'd1);
      check_eq("rst_out_data", 32'(out_data[d]), 32'd0);
      check_eq("rst_cfg_err", 32'(cfg_err[d]), 32'd0);
      check_eq("rst_pcp_w", 32'(pcp_w[d]), 32'd0);
      check_eq("rst_busy", 32'(busy[d]), 32'd0);
    end

    cfg_write(0, 0, 8'h01, 1'b0);
    cfg_write(0, 1, 8'h02, 1'b0);
    cfg_write(0, 2, 8'h04, 1'b0);
    cfg_write(0, 3, 8'h08, 1'b0);
    run_vec(0, 8'h05, 0, 8'h00, 0, 4'd0, 8'h00);
    check_eq("basic_0101", 32'(out_data[0]), 32'h5);

    run_vec(0, 8'h05, 5, 8'h0F, 0, 4'd0, 8'h00);
    run_vec(0, 8'h0F, 0, 8'h00, 0, 4'd0, 8'h00);

    run_vec(0, 8'h04, 0, 8'h00, 2, 4'd2, 8'hFF);
    cfg_write(2, 3, 8'hAA, 1'b1);
    step();
    check_eq("cfg_err_oor_clear", 32'(cfg_err[2]), 32'd0);
    run_vec(2, 8'hA5, 0, 8'h00, 0, 4'd0, 8'h00);

    cfg_we[0] = 1'b1;
    cfg_addr[0] = 4'd0;
    cfg_wdata[0] = 8'h04;
    wm[0][0] = 8'h04;
    run_vec(0, 8'h04, 0, 8'h00, 0, 4'd0, 8'h00);
    check_eq("same_cycle_0101", 32'(out_data[0]), 32'h5);

    in_valid[0] = 1'b1;
    in_data[0] = 8'h0F;
    step();
    in_valid[0] = 1'b0;
    repeat (5) step();
    check_eq("pre_rst_busy", 32'(busy[0]), 32'd1);
    check_eq("pre_rst_pcp_w", 32'(pcp_w[0]), 32'(wm[0][2]));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_eq("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("mid_rst_out_data", 32'(out_data[0]), 32'd0);
    check_eq("mid_rst_pcp_in", 32'(pcp_in[0]), 32'd0);
    check_eq("mid_rst_pcp_w", 32'(pcp_w[0]), 32'd0);
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) wm[d][i] = 8'h00;
    run_vec(0, 8'hFF, 0, 8'h00, 0, 4'd0, 8'h00);

    cfg_write(1, 0, 8'h03, 1'b0);
    cfg_write(1, 1, 8'h01, 1'b0);
    run_vec(1, 8'h01, 0, 8'h00, 0, 4'd0, 8'h00);
    check_eq("lat3_11", 32'(out_data[1]), 32'h3);

    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 4; it++) begin
        for (int i = 0; i < NN[d]; i++) cfg_write(d, i, 8'($urandom), 1'b0);
        run_vec(d, 8'($urandom), 0, 8'h00, 0, 4'd0, 8'h00);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
